// File: rtl/sma_pkg.sv
// Shared widths and types for the linear-interpolating upsampler.
// The widths used by the block follow its WIDTH/LOG2_R parameters, which default to these values.
package sma_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_LOG2_R = 2;
    localparam int R          = 1 << DEF_LOG2_R;

    typedef logic signed [DEF_WIDTH-1:0]            sample_t;
    typedef logic signed [DEF_WIDTH:0]              diff_t;
    typedef logic signed [DEF_WIDTH+DEF_LOG2_R:0]   acc_t;

endpackage

// File: rtl/sma_interp_step.sv
// Combinational arithmetic for one interpolation step: slope, burst start value,
// next accumulator and the scaled-down output sample.
module sma_interp_step
    import sma_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOG2_R = DEF_LOG2_R
) (
    input  logic signed [WIDTH-1:0]        i_x,
    input  logic signed [WIDTH-1:0]        i_x_prev,
    input  logic signed [WIDTH+LOG2_R:0]   i_acc,
    input  logic signed [WIDTH:0]          i_d,
    output logic signed [WIDTH:0]          o_d,
    output logic signed [WIDTH+LOG2_R:0]   o_acc_load,
    output logic signed [WIDTH+LOG2_R:0]   o_acc_next,
    output logic signed [WIDTH-1:0]        o_y
);

    assign o_d        = {i_x[WIDTH-1], i_x} - {i_x_prev[WIDTH-1], i_x_prev};
    assign o_acc_load = {{(LOG2_R+1){i_x_prev[WIDTH-1]}}, i_x_prev} <<< LOG2_R;
    assign o_acc_next = i_acc + {{LOG2_R{i_d[WIDTH]}}, i_d};

    // Floor shift by LOG2_R; the accumulator stays between two scaled samples, so this slice never overflows.
    assign o_y        = i_acc[LOG2_R +: WIDTH];

endmodule

// File: rtl/sma_interp.sv
// Linear-interpolating upsampler by 2**LOG2_R with valid/ready on both sides.
// Each accepted input starts a burst of R outputs that ramps from the previous input towards it.
module sma_interp
    import sma_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOG2_R = DEF_LOG2_R
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [WIDTH-1:0]  x,
    input  logic                     x_valid,
    output logic                     x_ready,
    output logic signed [WIDTH-1:0]  y,
    output logic                     y_valid,
    input  logic                     y_ready
);

    localparam logic [LOG2_R-1:0] PHASE_LAST = '1;

    logic signed [WIDTH-1:0]        r_x_prev;
    logic signed [WIDTH+LOG2_R:0]   r_acc;
    logic signed [WIDTH:0]          r_d;
    logic        [LOG2_R-1:0]       r_phase;
    logic                           r_y_valid;

    logic signed [WIDTH:0]          w_d;
    logic signed [WIDTH+LOG2_R:0]   w_acc_load;
    logic signed [WIDTH+LOG2_R:0]   w_acc_next;
    logic signed [WIDTH-1:0]        w_y;
    logic                           w_last;
    logic                           w_in_fire;
    logic                           w_out_fire;

    sma_interp_step #(
        .WIDTH  (WIDTH),
        .LOG2_R (LOG2_R)
    ) u_step (
        .i_x        (x),
        .i_x_prev   (r_x_prev),
        .i_acc      (r_acc),
        .i_d        (r_d),
        .o_d        (w_d),
        .o_acc_load (w_acc_load),
        .o_acc_next (w_acc_next),
        .o_y        (w_y)
    );

    // A new sample is taken when idle or exactly as the last output of a burst leaves.
    assign w_last     = (r_phase == PHASE_LAST);
    assign x_ready    = !r_y_valid || (w_last && y_ready);
    assign w_in_fire  = x_valid && x_ready;
    assign w_out_fire = r_y_valid && y_ready;

    assign y          = w_y;
    assign y_valid    = r_y_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_prev  <= '0;
            r_acc     <= '0;
            r_d       <= '0;
            r_phase   <= '0;
            r_y_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_d       <= w_d;
            r_acc     <= w_acc_load;
            r_x_prev  <= x;
            r_phase   <= '0;
            r_y_valid <= 1'b1;
        end else if (w_out_fire) begin
            if (w_last) begin
                r_y_valid <= 1'b0;
            end else begin
                r_acc   <= w_acc_next;
                r_phase <= r_phase + 1'b1;
            end
        end
    end

endmodule
